// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bit-level command encodings and byte controller states.
package i2c_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned CMD_W  = 4;

    localparam logic [CMD_W-1:0] CMD_NOP   = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_START = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_STOP  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_WRITE = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// I2C byte controller: sequences START / 8 data bits / ACK / STOP commands
// towards an external bit controller and reports completion with cmd_ack.
module i2c_master_byte_ctrl
    import i2c_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              read,
    input  logic              write,
    input  logic              ack_in,
    input  logic [DATA_W-1:0] din,
    output logic              cmd_ack,
    output logic              ack_out,
    output logic [DATA_W-1:0] dout,
    output logic              i2c_al,
    output logic [CMD_W-1:0]  bit_cmd,
    input  logic              bit_cmd_ack,
    input  logic              bit_al,
    output logic              bit_din,
    input  logic              bit_dout
);

    state_t              r_state, w_state_nxt;
    logic [CMD_W-1:0]    r_bit_cmd, w_bit_cmd_nxt;
    logic [DATA_W-1:0]   r_sr, w_sr_nxt;
    logic [CNT_W-1:0]    r_dcnt, w_dcnt_nxt;
    logic                r_cmd_ack, w_cmd_ack_nxt;
    logic                r_ack_out, w_ack_out_nxt;
    logic                r_bit_din, w_bit_din_nxt;
    logic                r_is_read, w_is_read_nxt;
    logic                r_i2c_al;
    logic                w_go;

    // A completing cycle blocks a new request so a held command cannot double-fire.
    assign w_go = (read | write | stop) & ~r_cmd_ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cmd <= CMD_NOP;
            r_sr      <= '0;
            r_dcnt    <= '0;
            r_cmd_ack <= 1'b0;
            r_ack_out <= 1'b0;
            r_bit_din <= 1'b0;
            r_is_read <= 1'b0;
            r_i2c_al  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cmd <= w_bit_cmd_nxt;
            r_sr      <= w_sr_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_cmd_ack <= w_cmd_ack_nxt;
            r_ack_out <= w_ack_out_nxt;
            r_bit_din <= w_bit_din_nxt;
            r_is_read <= w_is_read_nxt;
            r_i2c_al  <= bit_al;
        end
    end

    // Next-state and command sequencing
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cmd_nxt = r_bit_cmd;
        w_sr_nxt      = r_sr;
        w_dcnt_nxt    = r_dcnt;
        w_cmd_ack_nxt = 1'b0;
        w_ack_out_nxt = r_ack_out;
        w_bit_din_nxt = r_bit_din;
        w_is_read_nxt = r_is_read;

        if (bit_al) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cmd_nxt = CMD_NOP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        w_sr_nxt      = din;
                        w_dcnt_nxt    = CNT_W'(DATA_W - 1);
                        w_is_read_nxt = read;
                        if (start) begin
                            w_state_nxt   = ST_START;
                            w_bit_cmd_nxt = CMD_START;
                        end else if (read) begin
                            w_state_nxt   = ST_READ;
                            w_bit_cmd_nxt = CMD_READ;
                        end else if (write) begin
                            w_state_nxt   = ST_WRITE;
                            w_bit_cmd_nxt = CMD_WRITE;
                        end else begin
                            w_state_nxt   = ST_STOP;
                            w_bit_cmd_nxt = CMD_STOP;
                        end
                    end
                end
                ST_START: begin
                    if (bit_cmd_ack) begin
                        if (r_is_read) begin
                            w_state_nxt   = ST_READ;
                            w_bit_cmd_nxt = CMD_READ;
                        end else begin
                            w_state_nxt   = ST_WRITE;
                            w_bit_cmd_nxt = CMD_WRITE;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (bit_cmd_ack) begin
                        w_sr_nxt   = {r_sr[DATA_W-2:0], bit_dout};
                        w_dcnt_nxt = r_dcnt - CNT_W'(1);
                        if (r_dcnt == '0) begin
                            w_state_nxt = ST_ACK;
                            if (r_state == ST_WRITE) begin
                                w_bit_cmd_nxt = CMD_READ;
                            end else begin
                                w_bit_cmd_nxt = CMD_WRITE;
                                w_bit_din_nxt = ack_in;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (bit_cmd_ack) begin
                        w_ack_out_nxt = bit_dout;
                        if (stop) begin
                            w_state_nxt   = ST_STOP;
                            w_bit_cmd_nxt = CMD_STOP;
                        end else begin
                            w_state_nxt   = ST_IDLE;
                            w_bit_cmd_nxt = CMD_NOP;
                            w_cmd_ack_nxt = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_cmd_ack) begin
                        w_state_nxt   = ST_IDLE;
                        w_bit_cmd_nxt = CMD_NOP;
                        w_cmd_ack_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_bit_cmd_nxt = CMD_NOP;
                end
            endcase

            // SDA data bit always tracks the MSB of the shift register while writing.
            if (w_state_nxt == ST_WRITE) begin
                w_bit_din_nxt = w_sr_nxt[DATA_W-1];
            end
        end
    end

    assign cmd_ack = r_cmd_ack;
    assign ack_out = r_ack_out;
    assign dout    = r_sr;
    assign i2c_al  = r_i2c_al;
    assign bit_cmd = r_bit_cmd;
    assign bit_din = r_bit_din;

endmodule

// File: doc/i2c_master_byte_ctrl.md
I2C_MASTER_BYTE_CTRL -- requirements
Module: i2c_master_byte_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port start, input, 1, generate START before the byte.
REQ-004 SHALL have port stop, input, 1, generate STOP after the byte (or alone).
REQ-005 SHALL have port read, input, 1, read one byte.
REQ-006 SHALL have port write, input, 1, write one byte.
REQ-007 SHALL have port ack_in, input, 1, ACK bit master drives after a read (0=ACK, 1=NACK).
REQ-008 SHALL have port din, input, 8, byte to write.
REQ-009 SHALL have port cmd_ack, output, 1, one-cycle pulse when the requested sequence completes.
REQ-010 SHALL have port ack_out, output, 1, ACK bit sampled from slave after a write.
REQ-011 SHALL have port dout, output, 8, received byte (shift register contents).
REQ-012 SHALL have port i2c_al, output, 1, arbitration lost, registered copy of bit_al.
REQ-013 SHALL have port bit_cmd, output, 4, command to bit controller.
REQ-014 SHALL have port bit_cmd_ack, input, 1, bit command done pulse.
REQ-015 SHALL have port bit_al, input, 1, arbitration lost from bit controller.
REQ-016 SHALL have port bit_din, output, 1, SDA value for bit WRITE.
REQ-017 SHALL have port bit_dout, input, 1, SDA value sampled by bit controller.

Function
REQ-018 go SHALL be (read | write | stop) & ~cmd_ack; this blocks retrigger in the cycle cmd_ack is high.
REQ-019 FSM states SHALL be IDLE, START, READ, WRITE, ACK, STOP; they change only in IDLE on go, or on bit_cmd_ack.
REQ-020 IDLE with go: load sr<=din, dcnt<=7.
- Then priority: start -> START/CMD_START; read -> READ/CMD_READ; write -> WRITE/CMD_WRITE; else STOP/CMD_STOP.
REQ-021 START on bit_cmd_ack: read -> READ/CMD_READ; else WRITE/CMD_WRITE.
REQ-022 WRITE/READ on bit_cmd_ack:
- sr <= {sr[6:0], bit_dout}; dcnt decrements.
- When dcnt==0, go to ACK: after WRITE issue CMD_READ; after READ issue CMD_WRITE with bit_din=ack_in.
- Otherwise reissue the same command.
REQ-023 bit_din SHALL equal sr[7] in WRITE; it SHALL equal ack_in in ACK-after-read.
REQ-024 ACK on bit_cmd_ack: ack_out <= bit_dout.
- stop=1 -> STOP/CMD_STOP.
- stop=0 -> IDLE, bit_cmd=CMD_NOP, cmd_ack pulse.
REQ-025 STOP on bit_cmd_ack SHALL go to IDLE with bit_cmd=CMD_NOP and a cmd_ack pulse.
REQ-026 bit_cmd SHALL be registered and held stable until bit_cmd_ack; the next command SHALL be presented in the cycle after the ack.
REQ-027 On bit_al=1 (any state, highest priority after rst) the block SHALL:
- go to IDLE with bit_cmd=CMD_NOP and cmd_ack=0;
- set i2c_al=1 for the cycle after bit_al.
REQ-028 A bit_cmd_ack received in IDLE SHALL be ignored.
REQ-029 Inputs changing mid-sequence SHALL have no effect except stop and ack_in, which are sampled at the cycles defined above.

Reset
REQ-030 rst SHALL force the following, overriding any operation in progress:
- state=IDLE, bit_cmd=CMD_NOP, sr=0, dcnt=0;
- cmd_ack=0, ack_out=0, i2c_al=0, bit_din=0.

Structure
REQ-031 Package i2c_pkg SHALL hold the command constants CMD_NOP=4'b0000, CMD_START=4'b0001, CMD_STOP=4'b0010, CMD_WRITE=4'b0100, CMD_READ=4'b1000, and the state enum type; the bit controller SHALL use the same package.
REQ-032 No sub-module SHALL be used; the bit controller is connected at the parent level.

Verification
REQ-033 start+write, din=8'hA5, bench acks each bit_cmd after 3 cycles, bit_dout=0 in ACK ->
- bit_cmd sequence: START, 8×WRITE with bit_din 1,0,1,0,0,1,0,1, then READ;
- ack_out=0, one cmd_ack pulse.
REQ-034 read+stop, ack_in=1, bench returns bits of 8'h3C -> dout=8'h3C; ACK phase issues CMD_WRITE with bit_din=1, then CMD_STOP, then cmd_ack.
REQ-035 stop only -> single CMD_STOP, cmd_ack one cycle after its ack, then bit_cmd=CMD_NOP.
REQ-036 bit_al pulse during 4th WRITE bit -> IDLE, bit_cmd=CMD_NOP, i2c_al=1 next cycle, no cmd_ack.
REQ-037 rst asserted during READ bit 5 -> all outputs at reset values next cycle; a new write afterwards completes normally.
REQ-038 write held high through cmd_ack -> no retrigger in the ack cycle; a second byte starts the following cycle.
